// File: rtl/uart_pkg.sv
// Shared UART timing defaults and the accumulator width rule for the baud generator.
package uart_pkg;

  localparam int unsigned CLK_FREQ_DFLT   = 100_000_000;
  localparam int unsigned OVERSAMPLE_DFLT = 16;
  localparam int unsigned HALF            = OVERSAMPLE_DFLT / 2;

  function automatic int unsigned acc_width(input int unsigned rate_w, input int unsigned os);
    return rate_w + $clog2(os) + 1;
  endfunction

endpackage

// File: rtl/baud_nco.sv
// Bresenham accumulator producing tick_os at rate_bd*OVERSAMPLE Hz from clk.
// BAUD_GEN_RATE_CHECK_EN: flag over-range/zero rates on rate_err instead of clamping.
module baud_nco
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DFLT,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DFLT,
  parameter int unsigned RATE_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              resync,
  input  logic [RATE_W-1:0] rate_bd,
  output logic              tick_os,
  output logic              tick_fire,
  output logic              restart,
  output logic              rate_err
);

  localparam int unsigned ACC_W = acc_width(RATE_W, OVERSAMPLE);
  localparam int unsigned SUM_W = ACC_W + 1;
  localparam logic [SUM_W-1:0] FREQ = SUM_W'(CLK_FREQ);

  logic [RATE_W-1:0] rate_q;
  logic [ACC_W-1:0]  acc;
  logic [SUM_W-1:0]  inc;
  logic [SUM_W-1:0]  inc_eff;
  logic [SUM_W-1:0]  sum;
  logic              rate_chg;
  logic              err_c;

  assign inc      = SUM_W'(rate_q) * SUM_W'(OVERSAMPLE);
  assign rate_chg = (rate_bd != rate_q);

`ifdef BAUD_GEN_RATE_CHECK_EN
  assign err_c   = (inc > FREQ) || ((rate_q == '0) && en);
  assign inc_eff = inc;
`else
  assign err_c   = 1'b0;
  assign inc_eff = (inc > FREQ) ? FREQ : inc;
`endif

  assign sum       = SUM_W'(acc) + inc_eff;
  // a rate reload or resync restarts the phase and outranks any tick this cycle
  assign restart   = !en || rate_chg || resync;
  assign tick_fire = !restart && !err_c && (sum >= FREQ);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rate_q  <= '0;
      acc     <= '0;
      tick_os <= 1'b0;
    end else begin
      rate_q  <= rate_bd;
      tick_os <= tick_fire;
      if (restart || err_c)
        acc <= '0;
      else if (tick_fire)
        acc <= ACC_W'(sum - FREQ);
      else
        acc <= ACC_W'(sum);
    end
  end

`ifdef BAUD_GEN_RATE_CHECK_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      rate_err <= 1'b0;
    else
      rate_err <= err_c;
  end
`else
  assign rate_err = 1'b0;
`endif

endmodule

// File: rtl/baud_gen_os.sv
// Baud tick generator: oversampled NCO plus bit phase counter for tick_bd/tick_mid/clk_bd.
// BAUD_GEN_RATE_CHECK_EN enables the rate_err range check inside baud_nco.
module baud_gen_os
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FREQ   = CLK_FREQ_DFLT,
  parameter int unsigned OVERSAMPLE = OVERSAMPLE_DFLT,
  parameter int unsigned RATE_W     = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic [RATE_W-1:0] rate_bd,
  input  logic              resync,
  output logic              tick_os,
  output logic              tick_bd,
  output logic              tick_mid,
  output logic              clk_bd,
  output logic              rate_err
);

  localparam int unsigned CNT_W    = $clog2(OVERSAMPLE);
  localparam int unsigned HALF_BIT = OVERSAMPLE / 2;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [CNT_W-1:0] MID  = CNT_W'(HALF_BIT);

  logic             tick_fire;
  logic             restart;
  logic [CNT_W-1:0] os_cnt;
  logic [CNT_W-1:0] os_nxt;

  baud_nco #(
    .CLK_FREQ  (CLK_FREQ),
    .OVERSAMPLE(OVERSAMPLE),
    .RATE_W    (RATE_W)
  ) u_nco (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .resync   (resync),
    .rate_bd  (rate_bd),
    .tick_os  (tick_os),
    .tick_fire(tick_fire),
    .restart  (restart),
    .rate_err (rate_err)
  );

  always_comb begin
    os_nxt = os_cnt;
    if (restart)
      os_nxt = '0;
    else if (tick_fire)
      os_nxt = (os_cnt == LAST) ? '0 : os_cnt + 1'b1;
  end

  // driven from the NCO's decision so these land in the same cycle as tick_os
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      os_cnt   <= '0;
      tick_bd  <= 1'b0;
      tick_mid <= 1'b0;
      clk_bd   <= 1'b0;
    end else begin
      os_cnt   <= os_nxt;
      tick_bd  <= tick_fire && (os_cnt == LAST);
      tick_mid <= tick_fire && (os_nxt == MID);
      clk_bd   <= en && (os_nxt < MID);
    end
  end

endmodule

// File: doc/baud_gen_os.md
# baud_gen_os

Parametrised baud-tick generator for the UART. It supersedes the fixed bit-rate clock divider. An exact fractional (Bresenham) accumulator produces an oversampled tick stream at `rate_bd × OVERSAMPLE` Hz, with no divider hardware. From that stream it derives three outputs: a 1× bit tick, a mid-bit sample tick for the receiver, and a legacy square-wave `clk_bd`. It sits between the register file, which supplies `rate_bd`, and the UART TX/RX engines.

## Interface
- `CLK_FREQ`, default 100_000_000: system clock frequency in Hz, a positive integer.
- `OVERSAMPLE`, default 16: ticks per bit. Must be an even value ≥ 4.
- `RATE_W`, default 32: width of `rate_bd`.
- `clk`, input, 1: system clock. All logic is on the rising edge.
- `rst`, input, 1: asynchronous, active-low reset.
- `en`, input, 1: generator enable. When low, all state is held cleared.
- `rate_bd`, input, `RATE_W`: baud rate in Hz.
- `resync`, input, 1: single-cycle pulse that realigns the bit phase (RX start-bit edge).
- `tick_os`, output, 1: one-cycle pulse at `rate_bd × OVERSAMPLE` Hz on average.
- `tick_bd`, output, 1: one-cycle pulse at each bit boundary.
- `tick_mid`, output, 1: one-cycle pulse at mid-bit.
- `clk_bd`, output, 1: square wave at `rate_bd`. High for the first half of each bit.
- `rate_err`, output, 1: the programmed rate is unachievable (see Configuration).

## Operation
- Increment: `inc = rate_q × OVERSAMPLE`. The accumulator `acc` is `ACC_W = RATE_W + clog2(OVERSAMPLE) + 1` bits wide, unsigned.
- Each enabled cycle: `sum = acc + inc`.
  - If `sum ≥ CLK_FREQ`: `acc ← sum − CLK_FREQ` and fire `tick_os`.
  - Otherwise: `acc ← sum`.
- Long-run rate is exact: over `CLK_FREQ` cycles, exactly `rate_bd × OVERSAMPLE` ticks.
- Oversample counter `os_cnt` runs 0..`OVERSAMPLE`−1 and advances on each `tick_os`. On wrap to 0 it fires `tick_bd`.
- `tick_mid` fires on the `tick_os` that moves `os_cnt` to `OVERSAMPLE/2`.
- `clk_bd` is 1 while `os_cnt < OVERSAMPLE/2` and 0 otherwise. It is forced to 0 while disabled.
- `rate_q` register: loaded whenever `rate_bd ≠ rate_q`. The same cycle clears `acc` and `os_cnt` and suppresses all ticks, so the generator restarts with the new rate.
- `resync` (while enabled) clears `acc` and `os_cnt` and suppresses ticks in that cycle. The next `tick_mid` then lands half a bit after `resync`.
- `en` low:
  - `acc`, `os_cnt`, all ticks and `clk_bd` are forced to 0.
  - `rate_q` still tracks `rate_bd`.
  - On re-enable the generator starts from phase 0.
- Simultaneous events: a rate change or `resync` takes priority over a tick in the same cycle.
- `rate_bd = 0` produces no ticks. `acc` stays 0.

## Timing
- All outputs are registered. Reset value of every output is 0, and `acc`, `os_cnt` and `rate_q` reset to 0.
- The first `tick_os` after enabling or restarting occurs `ceil(CLK_FREQ / inc)` enabled edges later.
- The tick decision uses this cycle's `acc`. The pulse is visible in the cycle after the deciding edge.
- `tick_bd`, `tick_mid` and `clk_bd` change in the same cycle as the `tick_os` that causes them, so they have no extra latency.
- Reset is honoured immediately, mid-bit or mid-tick, with no residual pulse.

## Configuration
- Macro: `BAUD_GEN_RATE_CHECK_EN`.
- Defined:
  - `rate_err` = 1 whenever `inc > CLK_FREQ`, or `rate_bd = 0` while `en` = 1.
  - While `rate_err` is high, all ticks are suppressed and `acc` is held at 0. `rate_err` is registered and resets to 0.
- Undefined:
  - `rate_err` is tied to 0.
  - `inc` is clamped to `CLK_FREQ`, so over-range rates give `tick_os` every enabled cycle.

## Structure
- Shared package `uart_pkg` holds:
  - the `CLK_FREQ` and `OVERSAMPLE` defaults;
  - an `acc_width(rate_w, os)` function;
  - the localparam `HALF = OVERSAMPLE/2`.
- One sub-module, `baud_nco`: the rate register, accumulator, compare/subtract, clamp/check and `tick_os` generation.
- The top level `baud_gen_os` adds `os_cnt`, `tick_bd`, `tick_mid` and `clk_bd`.

## Test plan
- **Exact period.** `CLK_FREQ`=1000, `OVERSAMPLE`=4, `rate_bd`=50, `en`=1 after reset → `tick_os` every 5 cycles; `tick_bd` every 20; `tick_mid` 10 cycles after each `tick_bd`; `clk_bd` 10 high / 10 low.
- **Fractional rate.** Same parameters with `rate_bd`=60 → `tick_os` intervals 5,4,4,4,4,4 then repeating; exactly 6 ticks per 25 cycles.
- **Rate change mid-bit.** Change 50 → 100 on cycle 37 → no ticks that cycle; `os_cnt` = 0; first new `tick_os` 3 cycles later (`inc`=400).
- **Resync and enable.**
  - `resync` pulse at an arbitrary phase with `rate_bd`=50 → `tick_mid` exactly 10 cycles later and `tick_bd` 20 cycles later.
  - `en` dropped → all outputs 0 next cycle.
- **Reset mid-operation.** Assert `rst`=0 asynchronously between edges → all outputs 0 immediately. After release the first `tick_os` comes 5 enabled cycles later.
- **Range check.** `rate_bd`=300 (`inc`=1200 > 1000):
  - with `BAUD_GEN_RATE_CHECK_EN` → `rate_err`=1 and no ticks;
  - without → `rate_err`=0 and `tick_os` every cycle.
  - `rate_bd`=0 with `en`=1 → no ticks, plus `rate_err`=1 when checked.
